vx_operand_dispatch: RTL and testbench

Dispatch stage on the consumer side of the operand-collector output stream. It accepts one fully collected instruction per handshake (header, thread mask, three source-operand vectors) and routes it to the execution unit selected by `in_ex_type`. Wide warps are split into SIMD-width batches. Batches whose lanes are all inactive are skipped, and every emitted batch is tagged with packet id and start/end-of-packet flags. It sits between the operand-collector arbiter and the ALU/LSU/SFU dispatch ports of one issue slice.

---
 rtl/vx_operand_dispatch_if.sv | 49 ++++
 rtl/vx_operand_dispatch.sv | 153 +++++++++++++++
 tb/tb_vx_operand_dispatch.sv | 396 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vx_operand_dispatch_if.sv
// Dispatch bus: collected-instruction input stream plus the shared batch bus
// fanned out to the execution units. The master drives instructions in, the slave is the dispatcher.
interface vx_operand_dispatch_if #(
  parameter int NUM_THREADS  = 8,
  parameter int SIMD_WIDTH   = 4,
  parameter int NUM_EX_UNITS = 3,
  parameter int XLEN         = 32,
  parameter int HDR_W        = 64
);
  localparam int SIMD_COUNT = NUM_THREADS / SIMD_WIDTH;
  localparam int PID_W      = (SIMD_COUNT > 1) ? $clog2(SIMD_COUNT) : 1;
  localparam int EX_W       = (NUM_EX_UNITS > 1) ? $clog2(NUM_EX_UNITS) : 1;

  logic                        in_valid;
  logic                        in_ready;
  logic [EX_W-1:0]             in_ex_type;
  logic [NUM_THREADS-1:0]      in_tmask;
  logic [HDR_W-1:0]            in_hdr;
  logic [NUM_THREADS*XLEN-1:0] in_rs1;
  logic [NUM_THREADS*XLEN-1:0] in_rs2;
  logic [NUM_THREADS*XLEN-1:0] in_rs3;

  logic [NUM_EX_UNITS-1:0]     out_valid;
  logic [NUM_EX_UNITS-1:0]     out_ready;
  logic [HDR_W-1:0]            out_hdr;
  logic [SIMD_WIDTH-1:0]       out_tmask;
  logic [SIMD_WIDTH*XLEN-1:0]  out_rs1;
  logic [SIMD_WIDTH*XLEN-1:0]  out_rs2;
  logic [SIMD_WIDTH*XLEN-1:0]  out_rs3;
  logic [PID_W-1:0]            out_pid;
  logic                        out_sop;
  logic                        out_eop;

  modport master (
    output in_valid, in_ex_type, in_tmask, in_hdr, in_rs1, in_rs2, in_rs3,
    input  in_ready,
    input  out_valid, out_hdr, out_tmask, out_rs1, out_rs2, out_rs3,
    input  out_pid, out_sop, out_eop,
    output out_ready
  );

  modport slave (
    input  in_valid, in_ex_type, in_tmask, in_hdr, in_rs1, in_rs2, in_rs3,
    output in_ready,
    output out_valid, out_hdr, out_tmask, out_rs1, out_rs2, out_rs3,
    output out_pid, out_sop, out_eop,
    input  out_ready
  );
endinterface

// File: rtl/vx_operand_dispatch.sv
// Splits one collected instruction into SIMD-width batches, skips all-inactive batches, routes to one unit.
// Optional feature: define DISPATCH_PERF_EN to add the perf_stalls backpressure counter port.
module vx_operand_dispatch #(
  parameter int NUM_THREADS  = 8,
  parameter int SIMD_WIDTH   = 4,
  parameter int NUM_EX_UNITS = 3,
  parameter int XLEN         = 32,
  parameter int HDR_W        = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  vx_operand_dispatch_if.slave   bus,
  output logic [15:0]            illegal_cnt
`ifdef DISPATCH_PERF_EN
  ,
  output logic [43:0]            perf_stalls
`endif
);
  localparam int SIMD_COUNT = NUM_THREADS / SIMD_WIDTH;
  localparam int PID_W      = (SIMD_COUNT > 1) ? $clog2(SIMD_COUNT) : 1;
  localparam int EX_W       = (NUM_EX_UNITS > 1) ? $clog2(NUM_EX_UNITS) : 1;
  localparam int BATCH_W    = SIMD_WIDTH * XLEN;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]                  state_q, state_d;
  logic [EX_W-1:0]             exType_q, exType_d;
  logic [SIMD_COUNT-1:0]       busyMask_q, busyMask_d, inBusy;
  logic [PID_W-1:0]            cur_q, cur_d, firstIdx, nextIdx;
  logic                        sop_q, sop_d;
  logic [15:0]                 illegalCnt_q, illegalCnt_d;
  logic [NUM_THREADS-1:0]      tmask_q;
  logic [HDR_W-1:0]            hdr_q;
  logic [NUM_THREADS*XLEN-1:0] rs1_q, rs2_q, rs3_q;
  logic [NUM_EX_UNITS-1:0]     unitSel;
  logic                        sending, hasHigher, fire, lastBatch, accept, inIllegal;

  // Batch occupancy of the incoming mask, its lowest busy batch, and the next busy batch above cur.
  always_comb begin
    inBusy    = '0;
    firstIdx  = '0;
    nextIdx   = cur_q;
    hasHigher = 1'b0;
    for (int b = 0; b < SIMD_COUNT; b++) begin
      inBusy[b] = |bus.in_tmask[b*SIMD_WIDTH +: SIMD_WIDTH];
    end
    for (int b = SIMD_COUNT - 1; b >= 0; b--) begin
      if (inBusy[b]) firstIdx = PID_W'(b);
      if (busyMask_q[b] && (b > int'(cur_q))) begin
        hasHigher = 1'b1;
        nextIdx   = PID_W'(b);
      end
    end
  end

  always_comb begin
    unitSel = '0;
    for (int u = 0; u < NUM_EX_UNITS; u++) begin
      unitSel[u] = (int'(exType_q) == u);
    end
  end

  assign sending   = (state_q == SEND);
  assign lastBatch = ~hasHigher;
  assign fire      = |(bus.out_valid & bus.out_ready);
  assign inIllegal = (int'(bus.in_ex_type) >= NUM_EX_UNITS);
  assign accept    = bus.in_valid & bus.in_ready;

  // A new instruction may be taken while idle or on the very handshake that retires the last batch.
  assign bus.in_ready  = reset_n & (~sending | (fire & lastBatch));
  assign bus.out_valid = sending ? unitSel : '0;
  assign bus.out_pid   = cur_q;
  assign bus.out_sop   = sending & sop_q;
  assign bus.out_eop   = sending & lastBatch;
  assign bus.out_hdr   = hdr_q;
  assign bus.out_tmask = tmask_q[cur_q*SIMD_WIDTH +: SIMD_WIDTH];
  assign bus.out_rs1   = rs1_q[cur_q*BATCH_W +: BATCH_W];
  assign bus.out_rs2   = rs2_q[cur_q*BATCH_W +: BATCH_W];
  assign bus.out_rs3   = rs3_q[cur_q*BATCH_W +: BATCH_W];
  assign illegal_cnt   = illegalCnt_q;

  always_comb begin
    state_d      = state_q;
    exType_d     = exType_q;
    busyMask_d   = busyMask_q;
    cur_d        = cur_q;
    sop_d        = sop_q;
    illegalCnt_d = illegalCnt_q;
    if (accept) begin
      if (inIllegal) begin
        state_d = IDLE;
        if (illegalCnt_q != 16'hFFFF) illegalCnt_d = illegalCnt_q + 16'd1;
      end else begin
        state_d    = SEND;
        exType_d   = bus.in_ex_type;
        busyMask_d = inBusy;
        cur_d      = firstIdx;
        sop_d      = 1'b1;
      end
    end else if (fire) begin
      if (lastBatch) begin
        state_d = IDLE;
      end else begin
        cur_d = nextIdx;
        sop_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      exType_q     <= '0;
      busyMask_q   <= '0;
      cur_q        <= '0;
      sop_q        <= 1'b0;
      illegalCnt_q <= '0;
    end else begin
      state_q      <= state_d;
      exType_q     <= exType_d;
      busyMask_q   <= busyMask_d;
      cur_q        <= cur_d;
      sop_q        <= sop_d;
      illegalCnt_q <= illegalCnt_d;
    end
  end

  // Payload hold register needs no reset; it is only observed while a batch is valid.
  always_ff @(posedge clk) begin
    if (accept && !inIllegal) begin
      tmask_q <= bus.in_tmask;
      hdr_q   <= bus.in_hdr;
      rs1_q   <= bus.in_rs1;
      rs2_q   <= bus.in_rs2;
      rs3_q   <= bus.in_rs3;
    end
  end

`ifdef DISPATCH_PERF_EN
  logic [43:0] perfStalls_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      perfStalls_q <= '0;
    end else if (|(bus.out_valid & ~bus.out_ready)) begin
      perfStalls_q <= perfStalls_q + 44'd1;
    end
  end

  assign perf_stalls = perfStalls_q;
`endif
endmodule

// File: tb/tb_vx_operand_dispatch.sv
// Self-checking bench for vx_operand_dispatch: directed scenarios plus a randomized
// stream checked against a batch-queue reference model.
module tb_vx_operand_dispatch;
  localparam int NT = 8;
  localparam int SW = 4;
  localparam int NU = 3;
  localparam int XL = 32;
  localparam int HW = 64;
  localparam int SC = NT / SW;
  localparam int BW = SW * XL;
  localparam int OW = NU + 1 + 1 + 1 + SW + 3 * BW + HW;

  typedef logic [OW-1:0] ovec_t;
  typedef struct packed {
    logic [1:0]       ex;
    logic [NT-1:0]    tmask;
    logic [HW-1:0]    hdr;
    logic [NT*XL-1:0] rs1;
    logic [NT*XL-1:0] rs2;
    logic [NT*XL-1:0] rs3;
  } instr_t;
  typedef struct {
    instr_t ins;
    int     b;
    bit     sop;
    bit     eop;
  } batch_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] illegal_cnt;
`ifdef DISPATCH_PERF_EN
  logic [43:0] perf_stalls;
`endif
  int nTests = 0;
  int nFail  = 0;

  always #5 clk = ~clk;

  vx_operand_dispatch_if #(.NUM_THREADS(NT), .SIMD_WIDTH(SW), .NUM_EX_UNITS(NU),
                           .XLEN(XL), .HDR_W(HW)) bus ();

  vx_operand_dispatch #(.NUM_THREADS(NT), .SIMD_WIDTH(SW), .NUM_EX_UNITS(NU),
                        .XLEN(XL), .HDR_W(HW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .illegal_cnt(illegal_cnt)
`ifdef DISPATCH_PERF_EN
    ,
    .perf_stalls(perf_stalls)
`endif
  );

  function automatic instr_t mkInstr(logic [1:0] ex, logic [NT-1:0] tm);
    instr_t i;
    i.ex    = ex;
    i.tmask = tm;
    i.hdr   = {$urandom, $urandom};
    for (int t = 0; t < NT; t++) begin
      i.rs1[t*XL +: XL] = $urandom;
      i.rs2[t*XL +: XL] = $urandom;
      i.rs3[t*XL +: XL] = $urandom;
    end
    return i;
  endfunction

  function automatic ovec_t obsVec();
    return {bus.out_valid, bus.out_pid, bus.out_sop, bus.out_eop, bus.out_tmask,
            bus.out_rs1, bus.out_rs2, bus.out_rs3, bus.out_hdr};
  endfunction

  // Expected bus contents when batch b of instruction i is presented.
  function automatic ovec_t batchVec(instr_t i, int b, bit sop, bit eop);
    logic [NU-1:0] v;
    v = '0;
    v[i.ex] = 1'b1;
    return {v, 1'(b), sop, eop, i.tmask[b*SW +: SW],
            i.rs1[b*BW +: BW], i.rs2[b*BW +: BW], i.rs3[b*BW +: BW], i.hdr};
  endfunction

  task automatic drive(bit v, instr_t i, logic [NU-1:0] rdy);
    bus.in_valid   = v;
    bus.in_ex_type = i.ex;
    bus.in_tmask   = i.tmask;
    bus.in_hdr     = i.hdr;
    bus.in_rs1     = i.rs1;
    bus.in_rs2     = i.rs2;
    bus.in_rs3     = i.rs3;
    bus.out_ready  = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    instr_t a;
    a = mkInstr(2'd0, 8'hFF);
    reset_n = 1'b0;
    drive(1'b1, a, '1);
    tick();
    tick();
    #1;
    nTests++;
    if (bus.in_ready !== 1'b0) begin nFail++; $display("[TB] FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
    nTests++;
    if ({bus.out_valid, bus.out_pid, bus.out_sop, bus.out_eop} !== 6'd0) begin
      nFail++; $display("[TB] FAIL reset_outputs: got %b expected 000000", {bus.out_valid, bus.out_pid, bus.out_sop, bus.out_eop});
    end
    nTests++;
    if (illegal_cnt !== 16'd0) begin nFail++; $display("[TB] FAIL reset_illegal_cnt: got %h expected 0", illegal_cnt); end
`ifdef DISPATCH_PERF_EN
    nTests++;
    if (perf_stalls !== 44'd0) begin nFail++; $display("[TB] FAIL reset_perf: got %h expected 0", perf_stalls); end
`endif
    tick();
    reset_n = 1'b1;
    drive(1'b0, a, '1);
    #1;
    nTests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 3'b000) begin
      nFail++; $display("[TB] FAIL reset_release: got ready=%b valid=%b expected 1 000", bus.in_ready, bus.out_valid);
    end
    tick();
  endtask

  task automatic test_full_mask();
    instr_t a;
    a = mkInstr(2'd1, 8'hFF);
    drive(1'b1, a, '1);
    #1;
    nTests++;
    if (bus.in_ready !== 1'b1) begin nFail++; $display("[TB] FAIL full_accept: got %b expected 1", bus.in_ready); end
    tick();
    drive(1'b0, a, '1);
    #1;
    nTests++;
    if (obsVec() !== batchVec(a, 0, 1'b1, 1'b0)) begin
      nFail++; $display("[TB] FAIL full_pid0: got %h expected %h", obsVec(), batchVec(a, 0, 1'b1, 1'b0));
    end
    nTests++;
    if (bus.in_ready !== 1'b0) begin nFail++; $display("[TB] FAIL full_ready_mid: got %b expected 0", bus.in_ready); end
    tick();
    #1;
    nTests++;
    if (obsVec() !== batchVec(a, 1, 1'b0, 1'b1)) begin
      nFail++; $display("[TB] FAIL full_pid1: got %h expected %h", obsVec(), batchVec(a, 1, 1'b0, 1'b1));
    end
    nTests++;
    if (bus.in_ready !== 1'b1) begin nFail++; $display("[TB] FAIL full_ready_last: got %b expected 1", bus.in_ready); end
    tick();
    #1;
    nTests++;
    if (bus.out_valid !== 3'b000) begin nFail++; $display("[TB] FAIL full_idle: got %b expected 000", bus.out_valid); end
    tick();
  endtask

  task automatic test_skip_empty();
    instr_t a;
    a = mkInstr(2'd0, 8'hF0);
    drive(1'b1, a, '1);
    #1;
    tick();
    drive(1'b0, a, '1);
    #1;
    nTests++;
    if (obsVec() !== batchVec(a, 1, 1'b1, 1'b1)) begin
      nFail++; $display("[TB] FAIL skip_pid1: got %h expected %h", obsVec(), batchVec(a, 1, 1'b1, 1'b1));
    end
    tick();
    #1;
    nTests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 3'b000) begin
      nFail++; $display("[TB] FAIL skip_after: got ready=%b valid=%b expected 1 000", bus.in_ready, bus.out_valid);
    end
    tick();
  endtask

  task automatic test_zero_mask();
    instr_t a;
    a = mkInstr(2'd2, 8'h00);
    drive(1'b1, a, '1);
    #1;
    tick();
    drive(1'b0, a, '1);
    #1;
    nTests++;
    if (obsVec() !== batchVec(a, 0, 1'b1, 1'b1)) begin
      nFail++; $display("[TB] FAIL zero_pid0: got %h expected %h", obsVec(), batchVec(a, 0, 1'b1, 1'b1));
    end
    tick();
    #1;
    nTests++;
    if (bus.out_valid !== 3'b000) begin nFail++; $display("[TB] FAIL zero_idle: got %b expected 000", bus.out_valid); end
    tick();
  endtask

  task automatic test_backpressure();
    instr_t a;
`ifdef DISPATCH_PERF_EN
    logic [43:0] p0;
`endif
    a = mkInstr(2'd0, 8'hFF);
    drive(1'b1, a, '1);
    #1;
    tick();
    drive(1'b0, a, 3'b110);
`ifdef DISPATCH_PERF_EN
    p0 = perf_stalls;
`endif
    for (int k = 0; k < 3; k++) begin
      #1;
      nTests++;
      if (obsVec() !== batchVec(a, 0, 1'b1, 1'b0) || bus.in_ready !== 1'b0) begin
        nFail++; $display("[TB] FAIL bp_hold%0d: got %h ready=%b expected %h ready=0", k, obsVec(), bus.in_ready, batchVec(a, 0, 1'b1, 1'b0));
      end
      tick();
    end
    bus.out_ready = 3'b001;
    #1;
    nTests++;
    if (obsVec() !== batchVec(a, 0, 1'b1, 1'b0)) begin
      nFail++; $display("[TB] FAIL bp_release: got %h expected %h", obsVec(), batchVec(a, 0, 1'b1, 1'b0));
    end
`ifdef DISPATCH_PERF_EN
    nTests++;
    if (perf_stalls !== p0 + 44'd3) begin nFail++; $display("[TB] FAIL bp_perf: got %0d expected %0d", perf_stalls, p0 + 44'd3); end
`endif
    tick();
    #1;
    nTests++;
    if (obsVec() !== batchVec(a, 1, 1'b0, 1'b1) || bus.in_ready !== 1'b1) begin
      nFail++; $display("[TB] FAIL bp_pid1: got %h ready=%b expected %h ready=1", obsVec(), bus.in_ready, batchVec(a, 1, 1'b0, 1'b1));
    end
    tick();
    #1;
    tick();
  endtask

  task automatic test_back_to_back();
    instr_t a, b, c;
    a = mkInstr(2'd0, 8'hFF);
    b = mkInstr(2'd3, 8'hFF);
    c = mkInstr(2'd2, 8'h0F);
    drive(1'b1, a, '1);
    #1;
    tick();
    drive(1'b1, b, '1);
    #1;
    nTests++;
    if (obsVec() !== batchVec(a, 0, 1'b1, 1'b0) || bus.in_ready !== 1'b0) begin
      nFail++; $display("[TB] FAIL b2b_a0: got %h ready=%b expected %h ready=0", obsVec(), bus.in_ready, batchVec(a, 0, 1'b1, 1'b0));
    end
    tick();
    #1;
    nTests++;
    if (obsVec() !== batchVec(a, 1, 1'b0, 1'b1) || bus.in_ready !== 1'b1) begin
      nFail++; $display("[TB] FAIL b2b_a1: got %h ready=%b expected %h ready=1", obsVec(), bus.in_ready, batchVec(a, 1, 1'b0, 1'b1));
    end
    tick();
    drive(1'b1, c, '1);
    #1;
    nTests++;
    if (bus.out_valid !== 3'b000 || bus.in_ready !== 1'b1) begin
      nFail++; $display("[TB] FAIL b2b_illegal_silent: got valid=%b ready=%b expected 000 1", bus.out_valid, bus.in_ready);
    end
    nTests++;
    if (illegal_cnt !== 16'd1) begin nFail++; $display("[TB] FAIL b2b_illegal_cnt: got %0d expected 1", illegal_cnt); end
    tick();
    drive(1'b0, c, '1);
    #1;
    nTests++;
    if (obsVec() !== batchVec(c, 0, 1'b1, 1'b1)) begin
      nFail++; $display("[TB] FAIL b2b_c0: got %h expected %h", obsVec(), batchVec(c, 0, 1'b1, 1'b1));
    end
    tick();
    #1;
    nTests++;
    if (bus.out_valid !== 3'b000) begin nFail++; $display("[TB] FAIL b2b_idle: got %b expected 000", bus.out_valid); end
    tick();
  endtask

  task automatic test_reset_mid_packet();
    instr_t a;
    a = mkInstr(2'd1, 8'hFF);
    drive(1'b1, a, '1);
    #1;
    tick();
    drive(1'b0, a, '1);
    reset_n = 1'b0;
    #1;
    nTests++;
    if (obsVec() !== batchVec(a, 0, 1'b1, 1'b0) || bus.in_ready !== 1'b0) begin
      nFail++; $display("[TB] FAIL rstmid_pid0: got %h ready=%b expected %h ready=0", obsVec(), bus.in_ready, batchVec(a, 0, 1'b1, 1'b0));
    end
    tick();
    #1;
    nTests++;
    if ({bus.out_valid, bus.out_pid, bus.out_sop, bus.out_eop} !== 6'd0 || bus.in_ready !== 1'b0) begin
      nFail++; $display("[TB] FAIL rstmid_flush: got %b ready=%b expected 000000 ready=0", {bus.out_valid, bus.out_pid, bus.out_sop, bus.out_eop}, bus.in_ready);
    end
    nTests++;
    if (illegal_cnt !== 16'd0) begin nFail++; $display("[TB] FAIL rstmid_illegal_clr: got %0d expected 0", illegal_cnt); end
    reset_n = 1'b1;
    tick();
    #1;
    nTests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 3'b000) begin
      nFail++; $display("[TB] FAIL rstmid_resume: got ready=%b valid=%b expected 1 000", bus.in_ready, bus.out_valid);
    end
    tick();
  endtask

  // Reference model: a queue of batches still owed to the execution units.
  task automatic test_random();
    batch_t        expQ[$];
    batch_t        nb;
    int            expIll;
    int            idx[$];
    instr_t        ins;
    logic [NT-1:0] tm;
    logic [NU-1:0] rdy;
    bit            v, expReady;
    expIll = 0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      case ($urandom_range(0, 4))
        0:       tm = 8'h00;
        1:       tm = 8'h0F;
        2:       tm = 8'hF0;
        default: tm = 8'($urandom);
      endcase
      ins = mkInstr(2'($urandom_range(0, 3)), tm);
      v   = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b111;
      drive(v, ins, rdy);
      #1;
      expReady = (expQ.size() == 0) || (expQ.size() == 1 && rdy[expQ[0].ins.ex]);
      nTests++;
      if (bus.in_ready !== expReady) begin
        nFail++; $display("[TB] FAIL rand_in_ready cyc%0d: got %b expected %b", cyc, bus.in_ready, expReady);
      end
      nTests++;
      if (expQ.size() == 0) begin
        if (bus.out_valid !== 3'b000) begin
          nFail++; $display("[TB] FAIL rand_idle cyc%0d: got %b expected 000", cyc, bus.out_valid);
        end
      end else if (obsVec() !== batchVec(expQ[0].ins, expQ[0].b, expQ[0].sop, expQ[0].eop)) begin
        nFail++; $display("[TB] FAIL rand_batch cyc%0d: got %h expected %h", cyc, obsVec(),
                          batchVec(expQ[0].ins, expQ[0].b, expQ[0].sop, expQ[0].eop));
      end
      nTests++;
      if (illegal_cnt !== 16'(expIll)) begin
        nFail++; $display("[TB] FAIL rand_illegal cyc%0d: got %0d expected %0d", cyc, illegal_cnt, expIll);
      end
      if (expQ.size() > 0 && rdy[expQ[0].ins.ex]) void'(expQ.pop_front());
      if (v && expReady) begin
        if (ins.ex == 2'd3) begin
          expIll++;
        end else begin
          idx.delete();
          for (int b = 0; b < SC; b++) if (ins.tmask[b*SW +: SW] != '0) idx.push_back(b);
          if (idx.size() == 0) idx.push_back(0);
          for (int k = 0; k < idx.size(); k++) begin
            nb.ins = ins;
            nb.b   = idx[k];
            nb.sop = (k == 0);
            nb.eop = (k == idx.size() - 1);
            expQ.push_back(nb);
          end
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_full_mask();
    test_skip_empty();
    test_zero_mask();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_packet();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "[TB] timeout");
  end
endmodule
